// File: rtl/alu_pkg.sv
// Shared constants for the pipelined ALU: opcodes, FSM encoding and flag layout.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int FLAG_Z   = 0;
  localparam int FLAG_N   = 1;
  localparam int FLAG_C   = 2;
  localparam int FLAG_V   = 3;
  localparam int FLAG_ERR = 4;

  typedef logic [4:0] flags_t;

  function automatic flags_t pack_flags(input logic err, input logic v, input logic c,
                                        input logic n, input logic z);
    flags_t f;
    f           = '0;
    f[FLAG_ERR] = err;
    f[FLAG_V]   = v;
    f[FLAG_C]   = c;
    f[FLAG_N]   = n;
    f[FLAG_Z]   = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_serial.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH steps in total,
// the first step taken on the start edge so done pulses WIDTH-1 cycles after start.
module alu_mul_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               busy;

  logic [2*WIDTH-1:0] mc_cur;
  logic [2*WIDTH-1:0] acc_cur;
  logic [WIDTH-1:0]   mp_cur;

  // On start the operands bypass the registers so step one happens immediately
  always_comb begin
    mc_cur  = start ? {{WIDTH{1'b0}}, a} : mcand;
    mp_cur  = start ? b : mplier;
    acc_cur = start ? '0 : product;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (start || busy) begin
      product <= acc_cur + (mp_cur[0] ? mc_cur : '0);
      mcand   <= mc_cur << 1;
      mplier  <= mp_cur >> 1;
      cnt     <= start ? CW'(1) : cnt + CW'(1);
      busy    <= start ? 1'b1 : (cnt != CW'(WIDTH - 1));
      done    <= !start && (cnt == CW'(WIDTH - 1));
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops register at accept, MUL runs on the serial
// multiplier; the result is held in DONE until the consumer takes it.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic [4:0]       flags
);

  logic [1:0]         state;
  logic [WIDTH-1:0]   res;
  logic [WIDTH:0]     wide;
  logic [WIDTH:0]     b_ext;
  logic               res_c;
  logic               res_v;
  logic               res_err;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   mul_lo;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign mul_start = !rst && in_ready && in_valid && (ALU_Sel == OP_MUL);
  assign mul_lo    = mul_product[WIDTH-1:0];

  alu_mul_serial #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .product (mul_product)
  );

  // Carry/borrow falls out of the extra top bit of the widened add/sub
  always_comb begin
    res     = '0;
    wide    = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_err = 1'b0;
    b_ext   = {1'b0, B};
    case (ALU_Sel)
      OP_ADD: begin
        wide  = {1'b0, A} + {1'b0, B};
        res   = wide[WIDTH-1:0];
        res_c = wide[WIDTH];
        res_v = (A[WIDTH-1] == B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        wide  = {1'b0, A} - {1'b0, B};
        res   = wide[WIDTH-1:0];
        res_c = wide[WIDTH];
        res_v = (A[WIDTH-1] != B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_NOT: res = ~A;
      OP_XOR: res = A ^ B;
      OP_SHL: res = (b_ext >= (WIDTH+1)'(WIDTH)) ? '0 : A << B;
      OP_SHR: res = (b_ext >= (WIDTH+1)'(WIDTH)) ? '0 : A >> B;
      OP_MUL: res = '0;
      default: res_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ALU_Out <= '0;
      flags   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (ALU_Sel == OP_MUL) begin
              state <= ST_BUSY;
            end else begin
              state   <= ST_DONE;
              ALU_Out <= res;
              flags   <= pack_flags(res_err, res_v, res_c, res[WIDTH-1], res == '0);
            end
          end
        end
        ST_BUSY: begin
          if (mul_done) begin
            state   <= ST_DONE;
            ALU_Out <= mul_lo;
            flags   <= pack_flags(1'b0, 1'b0, |mul_product[2*WIDTH-1:WIDTH],
                                  mul_lo[WIDTH-1], mul_lo == '0);
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=8 with hand-computed results, flags and latencies.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] ALU_Sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] ALU_Out;
  logic [4:0] flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALU_Sel   (ALU_Sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALU_Out   (ALU_Out),
    .flags     (flags)
  );

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for a single accept edge, then scrambles the inputs and
  // counts edges (accept edge included) until out_valid shows up
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                               output int lat, output logic ready_seen);
    A        = a;
    B        = b;
    ALU_Sel  = sel;
    in_valid = 1'b1;
    tick();
    in_valid   = 1'b0;
    A          = ~a;
    B          = ~b;
    ALU_Sel    = 4'h1;
    lat        = 1;
    ready_seen = in_ready;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
      ready_seen = ready_seen | in_ready;
    end
  endtask

  // Handshake with a competing request present; it must not be taken
  task automatic finishOp();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    A         = 8'h01;
    B         = 8'h01;
    ALU_Sel   = 4'h0;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("hs_in_ready", 16'(in_ready), 16'h1);
    checkOutput("hs_out_valid", 16'(out_valid), 16'h0);
  endtask

  task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] sel, input logic [7:0] exp_out,
                       input logic [4:0] exp_flags, input int exp_lat);
    int   lat;
    logic rdy;
    applyStimulus(a, b, sel, lat, rdy);
    checkOutput({tag, "_lat"}, 16'(lat), 16'(exp_lat));
    checkOutput({tag, "_out"}, 16'(ALU_Out), 16'(exp_out));
    checkOutput({tag, "_flags"}, 16'(flags), 16'(exp_flags));
    checkOutput({tag, "_ready_busy"}, 16'(rdy), 16'h0);
    finishOp();
  endtask

  initial begin
    int   lat;
    logic rdy;
    int   stray;

    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    A         = 8'h12;
    B         = 8'h34;
    ALU_Sel   = 4'h0;
    tick();
    tick();
    checkOutput("rst_in_ready", 16'(in_ready), 16'h1);
    checkOutput("rst_out_valid", 16'(out_valid), 16'h0);
    checkOutput("rst_out", 16'(ALU_Out), 16'h0);
    checkOutput("rst_flags", 16'(flags), 16'h0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    checkOutput("post_rst_valid", 16'(out_valid), 16'h0);

    // flags order {ERR, V, C, N, Z}
    runOp("add_ff_01", 8'hFF, 8'h01, 4'h0, 8'h00, 5'b00101, 1);
    runOp("sub_80_01", 8'h80, 8'h01, 4'h1, 8'h7F, 5'b01000, 1);
    runOp("sub_01_02", 8'h01, 8'h02, 4'h1, 8'hFF, 5'b00110, 1);
    runOp("and",       8'hF0, 8'h3C, 4'h2, 8'h30, 5'b00000, 1);
    runOp("or",        8'h80, 8'h01, 4'h3, 8'h81, 5'b00010, 1);
    runOp("xor",       8'hF0, 8'hFF, 4'h5, 8'h0F, 5'b00000, 1);
    runOp("shl_01_08", 8'h01, 8'h08, 4'h6, 8'h00, 5'b00001, 1);
    runOp("shl_01_07", 8'h01, 8'h07, 4'h6, 8'h80, 5'b00010, 1);
    runOp("shr_80_07", 8'h80, 8'h07, 4'h7, 8'h01, 5'b00000, 1);
    runOp("shr_ff_09", 8'hFF, 8'h09, 4'h7, 8'h00, 5'b00001, 1);
    runOp("illegal_f", 8'h12, 8'h34, 4'hF, 8'h00, 5'b10001, 1);
    runOp("mul_10_11", 8'h10, 8'h11, 4'h8, 8'h10, 5'b00100, 9);
    runOp("mul_ff_ff", 8'hFF, 8'hFF, 4'h8, 8'h01, 5'b00100, 9);
    runOp("mul_07_06", 8'h07, 8'h06, 4'h8, 8'h2A, 5'b00000, 9);

    applyStimulus(8'h7F, 8'h01, 4'h0, lat, rdy);
    checkOutput("bp_lat", 16'(lat), 16'h1);
    in_valid = 1'b1;
    A        = 8'h03;
    B        = 8'h03;
    ALU_Sel  = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_out", 16'(ALU_Out), 16'h80);
      checkOutput("bp_flags", 16'(flags), 16'(5'b01010));
      checkOutput("bp_valid", 16'(out_valid), 16'h1);
      checkOutput("bp_ready", 16'(in_ready), 16'h0);
    end
    finishOp();

    // Leave a nonzero result registered so the abort visibly clears it
    runOp("not_55", 8'h55, 8'h00, 4'h4, 8'hAA, 5'b00010, 1);
    A        = 8'h10;
    B        = 8'h11;
    ALU_Sel  = 4'h8;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_valid", 16'(out_valid), 16'h0);
    checkOutput("abort_out", 16'(ALU_Out), 16'h0);
    checkOutput("abort_flags", 16'(flags), 16'h0);
    checkOutput("abort_ready", 16'(in_ready), 16'h1);
    stray = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) stray++;
    end
    checkOutput("abort_stray", 16'(stray), 16'h0);
    runOp("mul_03_05", 8'h03, 8'h05, 4'h8, 8'h0F, 5'b00000, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
